// File: rtl/pulse_stretcher_if.sv
// Trigger/config/status bundle between event logic and the pulse stretcher.
// The master side drives triggers and configuration; the slave side returns pulses and status.
interface pulse_stretcher_if #(
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned CNTR_WIDTH = 16,
  parameter int unsigned MISS_WIDTH = 32
);
  logic [CHANNELS-1:0]   din;
  logic [CHANNELS-1:0]   cfg_mask;
  logic [CNTR_WIDTH-1:0] cfg_width;
  logic [CNTR_WIDTH-1:0] cfg_holdoff;
  logic                  clr_missed;
  logic [CHANNELS-1:0]   dout;
  logic [CHANNELS-1:0]   busy;
  logic [MISS_WIDTH-1:0] sts_missed;

  modport master (
    output din, cfg_mask, cfg_width, cfg_holdoff, clr_missed,
    input  dout, busy, sts_missed
  );

  modport slave (
    input  din, cfg_mask, cfg_width, cfg_holdoff, clr_missed,
    output dout, busy, sts_missed
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Multi-channel output pulse generator: each accepted trigger yields a registered pulse of
// programmable width followed by a hold-off; triggers arriving while busy are counted as missed.
module pulse_stretcher #(
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned CNTR_WIDTH = 16,
  parameter int unsigned MISS_WIDTH = 32
) (
  input logic              aclk,
  input logic              areset,
  pulse_stretcher_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHigh, StHold} state_e;

  localparam logic [CNTR_WIDTH-1:0] CntZero = '0;
  localparam logic [CNTR_WIDTH-1:0] CntOne  = CNTR_WIDTH'(1);
  localparam int unsigned           PopW    = $clog2(CHANNELS + 1);
  localparam int unsigned           SumW    = ((MISS_WIDTH > PopW) ? MISS_WIDTH : PopW) + 1;
  localparam logic [MISS_WIDTH-1:0] MissMax = '1;

  logic [CHANNELS-1:0] pulse_vec;
  logic [CHANNELS-1:0] active_vec;
  logic [CHANNELS-1:0] miss_vec;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    state_e                state_q;
    logic [CNTR_WIDTH-1:0] cnt_q;
    logic [CNTR_WIDTH-1:0] hold_q;
    logic                  pulse_q;
    logic                  active_q;
    logic                  trig;

    assign trig = bus.din[g] & bus.cfg_mask[g];

    // Width goes straight into the down-counter; hold-off is parked until the high phase ends.
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        state_q  <= StIdle;
        cnt_q    <= '0;
        hold_q   <= '0;
        pulse_q  <= 1'b0;
        active_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (trig) begin
              hold_q <= bus.cfg_holdoff;
              if (bus.cfg_width != CntZero) begin
                state_q  <= StHigh;
                cnt_q    <= bus.cfg_width - CntOne;
                pulse_q  <= 1'b1;
                active_q <= 1'b1;
              end else if (bus.cfg_holdoff != CntZero) begin
                state_q  <= StHold;
                cnt_q    <= bus.cfg_holdoff - CntOne;
                active_q <= 1'b1;
              end
            end
          end
          StHigh: begin
            if (cnt_q != CntZero) begin
              cnt_q <= cnt_q - CntOne;
            end else begin
              pulse_q <= 1'b0;
              if (hold_q != CntZero) begin
                state_q <= StHold;
                cnt_q   <= hold_q - CntOne;
              end else begin
                state_q  <= StIdle;
                active_q <= 1'b0;
              end
            end
          end
          StHold: begin
            if (cnt_q != CntZero) begin
              cnt_q <= cnt_q - CntOne;
            end else begin
              state_q  <= StIdle;
              active_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= StIdle;
            pulse_q  <= 1'b0;
            active_q <= 1'b0;
          end
        endcase
      end
    end

    assign pulse_vec[g]  = pulse_q;
    assign active_vec[g] = active_q;
    assign miss_vec[g]   = trig & (state_q != StIdle);
  end

  logic [PopW-1:0]       miss_cnt;
  logic [SumW-1:0]       miss_sum;
  logic [MISS_WIDTH-1:0] missed_d;
  logic [MISS_WIDTH-1:0] missed_q;

  // Sum is one bit wider than either operand so a multi-channel add cannot wrap before saturating.
  always_comb begin
    miss_cnt = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      miss_cnt = miss_cnt + PopW'(miss_vec[i]);
    end
    miss_sum = SumW'(missed_q) + SumW'(miss_cnt);
    if (bus.clr_missed) begin
      missed_d = '0;
    end else if (miss_sum > SumW'(MissMax)) begin
      missed_d = MissMax;
    end else begin
      missed_d = MISS_WIDTH'(miss_sum);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      missed_q <= '0;
    end else begin
      missed_q <= missed_d;
    end
  end

  assign bus.dout       = pulse_vec;
  assign bus.busy       = active_vec;
  assign bus.sts_missed = missed_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: a default build plus a narrow-counter build for saturation.
module tb_pulse_stretcher;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  pulse_stretcher_if #(.CHANNELS(8), .CNTR_WIDTH(16), .MISS_WIDTH(32)) bus ();
  pulse_stretcher_if #(.CHANNELS(8), .CNTR_WIDTH(16), .MISS_WIDTH(4))  sbus ();

  pulse_stretcher #(.CHANNELS(8), .CNTR_WIDTH(16), .MISS_WIDTH(32)) u_dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus.slave)
  );

  pulse_stretcher #(.CHANNELS(8), .CNTR_WIDTH(16), .MISS_WIDTH(4)) u_sat (
    .aclk   (aclk),
    .areset (areset),
    .bus    (sbus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] dtr, btr;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    #1;
    chk("rst_dout", 32'(bus.dout), 32'h0);
    chk("rst_missed", bus.sts_missed, 32'h0);
    cyc(1);
    areset = 1'b0;
    cyc(1);
  endtask

  // dtr[k]/btr[k] hold dout/busy of channel ch in the cycle after trig[k] was presented.
  task automatic play(input int ch, input logic [31:0] trig, input int n,
                      output logic [31:0] d, output logic [31:0] b);
    d = '0;
    b = '0;
    for (int k = 0; k < n; k++) begin
      bus.din     = '0;
      bus.din[ch] = trig[k];
      cyc(1);
      d[k] = bus.dout[ch];
      b[k] = bus.busy[ch];
    end
    bus.din = '0;
  endtask

  initial begin
    bus.din = '0;  bus.cfg_mask = 8'hFF;  bus.cfg_width = 16'd4;  bus.cfg_holdoff = 16'd2;
    bus.clr_missed = 1'b0;
    sbus.din = '0; sbus.cfg_mask = 8'hFF; sbus.cfg_width = 16'd100; sbus.cfg_holdoff = 16'd0;
    sbus.clr_missed = 1'b0;
    #2;
    chk("rst_busy_hold", 32'(bus.busy), 32'h0);
    cyc(2);
    areset = 1'b0;
    cyc(1);
    chk("post_rst_dout", 32'(bus.dout), 32'h0);
    chk("post_rst_busy", 32'(bus.busy), 32'h0);
    chk("post_rst_missed", bus.sts_missed, 32'h0);

    // Single trigger W=4 H=2, re-accept at N+7.
    play(0, 32'h81, 9, dtr, btr);
    chk("single_dout", dtr, 32'h18F);
    chk("single_busy", btr, 32'h1BF);
    chk("single_missed", bus.sts_missed, 32'h0);

    // Retriggers at N, N+2, N+5, N+7.
    do_reset();
    play(0, 32'hA5, 9, dtr, btr);
    chk("retrig_dout", dtr, 32'h18F);
    chk("retrig_busy", btr, 32'h1BF);
    chk("retrig_missed", bus.sts_missed, 32'd2);

    // W=1 H=0, trigger held six cycles.
    do_reset();
    bus.cfg_width = 16'd1; bus.cfg_holdoff = 16'd0;
    play(3, 32'h3F, 6, dtr, btr);
    chk("w1h0_dout", dtr, 32'h15);
    chk("w1h0_missed", bus.sts_missed, 32'd3);

    // W=0 H=0: nothing happens.
    do_reset();
    bus.cfg_width = 16'd0; bus.cfg_holdoff = 16'd0;
    play(3, 32'h3F, 6, dtr, btr);
    chk("w0h0_dout", dtr, 32'h0);
    chk("w0h0_busy", btr, 32'h0);
    chk("w0h0_missed", bus.sts_missed, 32'h0);

    // W=0 H=2: hold-off only.
    bus.cfg_holdoff = 16'd2;
    play(5, 32'h01, 4, dtr, btr);
    chk("w0h2_dout", dtr, 32'h0);
    chk("w0h2_busy", btr, 32'h3);

    // Mask 0x0F, two all-channel strobes back to back, W=3.
    do_reset();
    bus.cfg_mask = 8'h0F; bus.cfg_width = 16'd3; bus.cfg_holdoff = 16'd0;
    bus.din = 8'hFF;
    cyc(1);
    chk("mask_dout1", 32'(bus.dout), 32'h0F);
    chk("mask_busy1", 32'(bus.busy), 32'h0F);
    cyc(1);
    bus.din = 8'h00;
    chk("mask_dout2", 32'(bus.dout), 32'h0F);
    chk("mask_missed", bus.sts_missed, 32'd4);
    cyc(1);
    chk("mask_dout3", 32'(bus.dout), 32'h0F);
    cyc(1);
    chk("mask_dout4", 32'(bus.dout), 32'h0);
    bus.clr_missed = 1'b1;
    cyc(1);
    bus.clr_missed = 1'b0;
    chk("clr_missed", bus.sts_missed, 32'h0);

    // Saturation on the 4-bit miss counter.
    sbus.din = 8'h07;
    cyc(1);
    chk("sat_accept", 32'(sbus.sts_missed), 32'h0);
    cyc(4);
    chk("sat_12", 32'(sbus.sts_missed), 32'd12);
    sbus.din = 8'h03;
    cyc(1);
    chk("sat_14", 32'(sbus.sts_missed), 32'd14);
    sbus.din = 8'h07;
    cyc(1);
    chk("sat_15", 32'(sbus.sts_missed), 32'd15);
    cyc(1);
    chk("sat_hold", 32'(sbus.sts_missed), 32'd15);
    sbus.clr_missed = 1'b1;
    cyc(1);
    chk("sat_clr_wins", 32'(sbus.sts_missed), 32'h0);
    sbus.clr_missed = 1'b0;
    sbus.din = 8'h00;

    // In-flight pulse keeps its latched width; next pulse uses the new one.
    do_reset();
    bus.cfg_mask = 8'hFF; bus.cfg_width = 16'd8; bus.cfg_holdoff = 16'd0;
    dtr = '0;
    for (int k = 0; k < 12; k++) begin
      bus.din = ((k == 0) || (k == 9)) ? 8'h02 : 8'h00;
      if (k == 2) bus.cfg_width = 16'd2;
      cyc(1);
      dtr[k] = bus.dout[1];
    end
    bus.din = 8'h00;
    chk("cfg_change_dout", dtr, 32'h6FF);

    // Asynchronous reset mid-pulse.
    bus.cfg_width = 16'd8;
    bus.din = 8'h04;
    cyc(2);
    bus.din = 8'h00;
    cyc(1);
    chk("pre_arst_missed", bus.sts_missed, 32'd1);
    chk("pre_arst_dout", 32'(bus.dout), 32'h04);
    #3;
    areset = 1'b1;
    #1;
    chk("arst_dout", 32'(bus.dout), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_missed", bus.sts_missed, 32'h0);
    #2;
    areset = 1'b0;
    cyc(1);
    bus.din = 8'h04;
    cyc(1);
    bus.din = 8'h00;
    chk("post_arst_accept", 32'(bus.dout), 32'h04);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
